mem_port_arbiter: RTL

//   Shares one single-ported synchronous memory between the core's two memory clients.

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 16 +
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, client port ids
// and the largest memory latency the WAIT counter can cover.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic PORT_DATA  = 1'b0;
    localparam logic PORT_FETCH = 1'b1;

    localparam int MEM_LAT_MAX = 7;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant policy: data port wins unless the fetch port has been starved, in which
// case a contended cycle goes to fetch.
module mem_arb_pick
    import riscv_mem_pkg::*;
(
    input  logic i_req_0,
    input  logic i_req_1,
    input  logic i_starve,
    output logic o_vld,
    output logic o_port
);

    assign o_vld  = i_req_0 | i_req_1;
    assign o_port = (i_req_1 & (~i_req_0 | i_starve)) ? PORT_FETCH : PORT_DATA;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between the data (port 0) and
// instruction-fetch (port 1) clients with a req/ack handshake.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int MAW     = 14,
    parameter int MEM_LAT = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_req_0,
    input  logic           i_we_0,
    input  logic [AW-1:0]  i_addr_0,
    input  logic [31:0]    i_wdata_0,
    input  logic [3:0]     i_be_0,
    output logic           o_ack_0,
    output logic [31:0]    o_rdata_0,
    input  logic           i_req_1,
    input  logic [AW-1:0]  i_addr_1,
    output logic           o_ack_1,
    output logic [31:0]    o_rdata_1,
    output logic           o_mem_en,
    output logic           o_mem_we,
    output logic [3:0]     o_mem_be,
    output logic [MAW-1:0] o_mem_addr,
    output logic [31:0]    o_mem_wdata,
    input  logic [31:0]    i_mem_rdata,
    output logic           o_busy
);

    localparam int LP_LAT = (MEM_LAT < 1) ? 1 :
                            (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [2:0] LP_CNT_INIT = 3'(LP_LAT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic       r_starve;
    logic       r_port;
    logic       r_we;
    logic       w_pick_vld;
    logic       w_pick_port;
    logic       w_unused;

    // Byte-offset bits and bits above the memory window never reach the memory.
    assign w_unused = ^{i_addr_0[AW-1:MAW+2], i_addr_0[1:0],
                        i_addr_1[AW-1:MAW+2], i_addr_1[1:0]};

    mem_arb_pick u_pick (
        .i_req_0  (i_req_0),
        .i_req_1  (i_req_1),
        .i_starve (r_starve),
        .o_vld    (w_pick_vld),
        .o_port   (w_pick_port)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_vld) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (r_cnt == 3'd0) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt       <= 3'd0;
            r_starve    <= 1'b0;
            r_port      <= PORT_DATA;
            r_we        <= 1'b0;
            o_ack_0     <= 1'b0;
            o_ack_1     <= 1'b0;
            o_rdata_0   <= 32'h0;
            o_rdata_1   <= 32'h0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= 4'h0;
            o_mem_addr  <= '0;
            o_mem_wdata <= 32'h0;
            o_busy      <= 1'b0;
        end else begin
            o_mem_en <= 1'b0;
            o_mem_we <= 1'b0;
            o_ack_0  <= 1'b0;
            o_ack_1  <= 1'b0;
            o_busy   <= (w_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_port   <= w_pick_port;
                        o_mem_en <= 1'b1;
                        if (w_pick_port == PORT_FETCH) begin
                            r_we        <= 1'b0;
                            r_starve    <= 1'b0;
                            o_mem_we    <= 1'b0;
                            o_mem_be    <= 4'hF;
                            o_mem_addr  <= i_addr_1[MAW+1:2];
                            o_mem_wdata <= 32'h0;
                        end else begin
                            r_we        <= i_we_0;
                            o_mem_we    <= i_we_0;
                            o_mem_be    <= i_be_0;
                            o_mem_addr  <= i_addr_0[MAW+1:2];
                            o_mem_wdata <= i_wdata_0;
                            if (i_req_1) r_starve <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: r_cnt <= LP_CNT_INIT;
                ST_WAIT: begin
                    // Read data is valid only in the final WAIT cycle.
                    if (r_cnt == 3'd0) begin
                        if (r_port == PORT_DATA) o_ack_0 <= 1'b1;
                        else                     o_ack_1 <= 1'b1;
                        if (!r_we) begin
                            if (r_port == PORT_DATA) o_rdata_0 <= i_mem_rdata;
                            else                     o_rdata_1 <= i_mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
